button_conditioner: RTL and testbench

//  Conditions the two raw duty-cycle push-buttons before they reach the PWM duty stage.
//  - Synchronises each button and debounces it.
//  - Emits one-clock step pulses: one on press, then auto-repeat while the button is held.
//  - inc_pulse_out / dec_pulse_out drive the PWM block's increase/decrease inputs directly.

---
 rtl/dc_pkg.sv | 21 ++
 rtl/button_channel.sv | 115 +++++++++++
 rtl/button_conditioner.sv | 69 ++++++
 tb/tb_button_conditioner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// Shared types and default timing for the duty-cycle button conditioner.
package dc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } ch_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 64;
  localparam int DEF_REPEAT_CYCLES   = 16;
  localparam int DEF_REPEAT_EN       = 1;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce filter and press/auto-repeat FSM.
// raw_pulse_out is registered and one clock wide per step request.
import dc_pkg::*;

module button_channel #(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic db_out,
  output logic raw_pulse_out
);

  localparam int CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int TMR_MAX = ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) - 1;
  localparam int TMR_W   = cnt_width(TMR_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   db_q, db_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  ch_state_e              state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   pulse_q, pulse_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  // Any sample agreeing with db restarts the stability count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (db_q) begin
          pulse_d = 1'b1;
          state_d = ST_HOLD;
          tmr_d   = '0;
        end
      end
      ST_HOLD: begin
        if (!db_q) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) begin
          if (REPEAT_EN != 0) begin
            pulse_d = 1'b1;
            state_d = ST_REPEAT;
            tmr_d   = '0;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!db_q) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(REPEAT_CYCLES - 1)) begin
          pulse_d = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_d;
    end
  end

  assign db_out        = db_q;
  assign raw_pulse_out = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Two button channels plus chord lockout: a step on one channel is dropped
// while the opposite button is debounced-high.
import dc_pkg::*;

module button_conditioner #(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_btn_in,
  input  logic dec_btn_in,
  output logic inc_pulse_out,
  output logic dec_pulse_out,
  output logic inc_held_out,
  output logic dec_held_out
);

  logic inc_db, dec_db, inc_raw, dec_raw;
  logic inc_pulse_q, inc_pulse_d, dec_pulse_q, dec_pulse_d;
  logic inc_held_q, inc_held_d, dec_held_q, dec_held_d;

  button_channel #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(REPEAT_EN)
  ) u_inc (
    .clk(clk), .reset(reset), .btn_in(inc_btn_in),
    .db_out(inc_db), .raw_pulse_out(inc_raw)
  );

  button_channel #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(REPEAT_EN)
  ) u_dec (
    .clk(clk), .reset(reset), .btn_in(dec_btn_in),
    .db_out(dec_db), .raw_pulse_out(dec_raw)
  );

  // Simultaneous presses lock each other out, so neither steps.
  always_comb begin
    inc_pulse_d = inc_raw & ~dec_db;
    dec_pulse_d = dec_raw & ~inc_db;
    inc_held_d  = inc_db;
    dec_held_d  = dec_db;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
      inc_held_q  <= 1'b0;
      dec_held_q  <= 1'b0;
    end else begin
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
      inc_held_q  <= inc_held_d;
      dec_held_q  <= dec_held_d;
    end
  end

  assign inc_pulse_out = inc_pulse_q;
  assign dec_pulse_out = dec_pulse_q;
  assign inc_held_out  = inc_held_q;
  assign dec_held_out  = dec_held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: u0 uses defaults, u1 has auto-repeat disabled;
// both see the same stimulus and are compared every cycle against a press-age model.
module tb_button_conditioner;

  localparam int S = 2, D = 4, H = 64, R = 16;

  logic clk = 1'b0;
  logic reset, inc_btn, dec_btn;
  logic [1:0] inc_p, dec_p, inc_h, dec_h;

  int checks = 0, errors = 0, cyc = 0;

  button_conditioner u0 (
    .clk(clk), .reset(reset), .inc_btn_in(inc_btn), .dec_btn_in(dec_btn),
    .inc_pulse_out(inc_p[0]), .dec_pulse_out(dec_p[0]),
    .inc_held_out(inc_h[0]), .dec_held_out(dec_h[0])
  );

  button_conditioner #(.REPEAT_EN(0)) u1 (
    .clk(clk), .reset(reset), .inc_btn_in(inc_btn), .dec_btn_in(dec_btn),
    .inc_pulse_out(inc_p[1]), .dec_pulse_out(dec_p[1]),
    .inc_held_out(inc_h[1]), .dec_held_out(dec_h[1])
  );

  always #5 clk = ~clk;

  // Reference model: [dut][ch], ch 0 = inc, 1 = dec.
  bit m_sync [2][S];
  bit m_db [2];
  int m_run [2];
  int m_age [2];
  bit m_raw [2][2];
  bit m_pls [2][2];
  bit m_held [2];

  int qi[$], qd[$], exp_q[$];
  int ni [2], nd [2];
  bit inc_seen, dec_seen;

  typedef struct {
    bit rst; bit inc; bit dec; int len;
    int e_i0; int e_d0; int e_i1; int e_d1;
  } phase_t;
  phase_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Steps are issued when the debounced level has been high for an age of 0,
  // HOLD, HOLD+REPEAT, ... edges; outputs lag one more register.
  task automatic model_edge(input bit i, input bit d, input bit r);
    bit btn [2];
    bit s;
    btn[0] = i; btn[1] = d;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < S; k++) m_sync[c][k] = 1'b0;
        m_db[c] = 1'b0; m_run[c] = 0; m_age[c] = -1; m_held[c] = 1'b0;
        for (int u = 0; u < 2; u++) begin m_raw[u][c] = 1'b0; m_pls[u][c] = 1'b0; end
      end
    end else begin
      for (int u = 0; u < 2; u++)
        for (int c = 0; c < 2; c++) m_pls[u][c] = m_raw[u][c] & ~m_db[1-c];
      for (int c = 0; c < 2; c++) begin
        m_held[c] = m_db[c];
        m_age[c] = m_db[c] ? m_age[c] + 1 : -1;
        for (int u = 0; u < 2; u++)
          m_raw[u][c] = (m_age[c] == 0) ||
                        (u == 0 && m_age[c] >= H && ((m_age[c] - H) % R) == 0);
        s = m_sync[c][S-1];
        if (s != m_db[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin m_db[c] = s; m_run[c] = 0; end
        end else begin
          m_run[c] = 0;
        end
        for (int k = S-1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
        m_sync[c][0] = btn[c];
      end
    end
  endtask

  task automatic step(input bit i, input bit d, input bit r);
    inc_btn = i; dec_btn = d; reset = r;
    @(posedge clk);
    cyc++;
    model_edge(i, d, r);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d.inc_pulse_out", u), int'(inc_p[u]), int'(m_pls[u][0]));
      chk($sformatf("u%0d.dec_pulse_out", u), int'(dec_p[u]), int'(m_pls[u][1]));
      chk($sformatf("u%0d.inc_held_out", u),  int'(inc_h[u]), int'(m_held[0]));
      chk($sformatf("u%0d.dec_held_out", u),  int'(dec_h[u]), int'(m_held[1]));
      if (inc_p[u]) ni[u]++;
      if (dec_p[u]) nd[u]++;
    end
    if (inc_p[0]) qi.push_back(cyc);
    if (dec_p[0]) qd.push_back(cyc);
    if (inc_h[0]) inc_seen = 1'b1;
    if (dec_h[0]) dec_seen = 1'b1;
  endtask

  task automatic clr();
    qi.delete(); qd.delete(); exp_q.delete();
    ni = '{0, 0}; nd = '{0, 0};
    inc_seen = 1'b0; dec_seen = 1'b0;
  endtask

  // Compares u0 pulse edges (relative to k) against exp_q.
  task automatic chk_q(input string name, input bit use_dec, input int k);
    int got[$];
    if (use_dec) got = qd; else got = qi;
    chk({name, ".count"}, got.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++)
      chk($sformatf("%s.edge%0d", name, j), (j < got.size()) ? got[j] - k : -1, exp_q[j]);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    inc_btn = 1'b0; dec_btn = 1'b0; reset = 1'b1;
    m_age = '{-1, -1};
    clr();

    // rst inc dec len | u0 inc/dec pulses | u1 inc/dec pulses
    tbl.push_back('{1, 0, 0,   2,  0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  40,  1, 0, 1, 0});
    tbl.push_back('{0, 0, 0,  20,  0, 0, 0, 0});
    for (int j = 0; j < 5; j++) begin
      tbl.push_back('{0, 1, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 2, 0, 0, 0, 0});
    end
    tbl.push_back('{0, 0, 0,  10,  0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 120,  0, 5, 0, 1});
    tbl.push_back('{0, 0, 0,  40,  0, 0, 0, 0});
    tbl.push_back('{0, 1, 1,  40,  0, 0, 0, 0});
    tbl.push_back('{0, 0, 0,  20,  0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 200, 10, 0, 1, 0});
    tbl.push_back('{0, 0, 0,  30,  0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  30,  1, 0, 1, 0});
    tbl.push_back('{0, 0, 0,  30,  0, 0, 0, 0});

    foreach (tbl[p]) begin
      clr();
      repeat (tbl[p].len) step(tbl[p].inc, tbl[p].dec, tbl[p].rst);
      chk($sformatf("tbl%0d.u0.inc_cnt", p), ni[0], tbl[p].e_i0);
      chk($sformatf("tbl%0d.u0.dec_cnt", p), nd[0], tbl[p].e_d0);
      chk($sformatf("tbl%0d.u1.inc_cnt", p), ni[1], tbl[p].e_i1);
      chk($sformatf("tbl%0d.u1.dec_cnt", p), nd[1], tbl[p].e_d1);
      if (p == 0) begin
        chk("reset.outputs", int'({inc_p, dec_p, inc_h, dec_h}), 0);
      end
      if (p >= 3 && p <= 13) chk($sformatf("bounce%0d.held", p), int'(inc_seen), 0);
    end

    // Exact press latency and held timing.
    clr(); k = cyc + 1;
    for (int n = 0; n < 40; n++) begin
      step(1'b1, 1'b0, 1'b0);
      if (n == 5) chk("press.held_before", int'(inc_h[0]), 0);
      if (n == 6) chk("press.held_rise", int'(inc_h[0]), 1);
    end
    exp_q = '{7};
    chk_q("press.inc", 1'b0, k);
    chk("press.dec_cnt", qd.size(), 0);
    idle(25);

    // Auto-repeat timing, nothing after release.
    clr(); k = cyc + 1;
    repeat (120) step(1'b0, 1'b1, 1'b0);
    exp_q = '{7, 71, 87, 103, 119};
    chk_q("repeat.dec", 1'b1, k);
    clr();
    idle(40);
    chk("repeat.after_release", qd.size(), 0);

    // Chord: dec pressed 20 clocks into an inc hold.
    clr(); k = cyc + 1;
    for (int n = 0; n < 90; n++) step(1'b1, (n >= 20 && n < 50), 1'b0);
    exp_q = '{7, 71, 87};
    chk_q("chord.inc", 1'b0, k);
    chk("chord.dec_cnt", qd.size(), 0);
    chk("chord.dec_held_seen", int'(dec_seen), 1);
    idle(25);

    // Chord overlapping the first repeat: that step is dropped, the next survives.
    clr(); k = cyc + 1;
    for (int n = 0; n < 90; n++) step(1'b1, (n >= 60 && n < 80), 1'b0);
    exp_q = '{7, 87};
    chk_q("chord2.inc", 1'b0, k);
    chk("chord2.dec_cnt", qd.size(), 0);
    idle(25);

    // Reset while held: treated as a fresh press afterwards.
    clr(); k = cyc + 1;
    for (int n = 0; n < 70; n++) begin
      step(1'b1, 1'b0, (n == 50));
      if (n == 50) chk("rst_hold.outputs", int'({inc_p, dec_p, inc_h, dec_h}), 0);
    end
    exp_q = '{7, 58};
    chk_q("rst_hold.inc", 1'b0, k);
    idle(25);

    // Randomised runs against the model.
    for (int r = 0; r < 40; r++) begin
      bit ri, rd;
      int len;
      ri = bit'($urandom_range(0, 1));
      rd = bit'($urandom_range(0, 1));
      len = $urandom_range(1, 100);
      for (int n = 0; n < len; n++)
        step(ri ^ (n < 4 && $urandom_range(0, 1) == 1),
             rd ^ (n < 4 && $urandom_range(0, 1) == 1),
             $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
